vga_rect_filler: RTL

- Local-bus initiator that writes VRAM; it drives the sel/addr/we/qin/qout port that the VGA controller exposes as a responder.
- Fills a clipped rectangle in the 640x480 12-bit framebuffer with a constant colour, one pixel per bus cycle.
- Sits beside the CPU on the VRAM bus behind a request/grant mux, so bulk screen clears and boxes do not cost CPU store loops.

---
 rtl/vga_rect_filler_pkg.sv | 25 ++
 rtl/vga_rect_filler_walker.sv | 63 ++++++
 rtl/vga_rect_filler.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_rect_filler_pkg.sv
// Shared constants for the VRAM rectangle filler: framebuffer geometry,
// bus write-enable codes, FSM state encodings and the row-base helper.
package vga_rect_filler_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam logic [2:0] WE_PIXEL = 3'b010;
  localparam logic [2:0] WE_NONE  = 3'b000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_RD    = 3'd3;
  localparam logic [2:0] ST_WR    = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // y*640 + x built from shifts so no multiplier is inferred.
  function automatic logic [18:0] row_base(input logic [8:0] y, input logic [9:0] x);
    logic [18:0] yw;
    yw = {10'd0, y};
    return (yw << 9) + (yw << 7) + {9'd0, x};
  endfunction

endpackage

// File: rtl/vga_rect_filler_walker.sv
// Pixel walker for the rectangle filler: column/row counters, row-base
// accumulator and last-pixel flag. load and advance may coincide, in which
// case the walker loads the rectangle origin and steps past it in one cycle.
module vga_fill_walker
  import vga_rect_filler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        advance_i,
  input  logic [9:0]  cw_i,
  input  logic [8:0]  ch_i,
  input  logic [18:0] base_i,
  output logic [18:0] pix_addr_o,
  output logic        last_o
);

  logic [9:0]  col_q, col_d, cw_q, cur_cw, cur_col;
  logic [8:0]  row_q, row_d, ch_q, cur_ch, cur_row;
  logic [18:0] base_q, base_d, cur_base;

  // Current position is the freshly loaded origin on a load cycle, else the stored one.
  always_comb begin
    cur_col  = load_i ? 10'd0  : col_q;
    cur_row  = load_i ? 9'd0   : row_q;
    cur_base = load_i ? base_i : base_q;
    cur_cw   = load_i ? cw_i   : cw_q;
    cur_ch   = load_i ? ch_i   : ch_q;
    col_d    = cur_col;
    row_d    = cur_row;
    base_d   = cur_base;
    if (advance_i) begin
      if (cur_col == cur_cw - 10'd1) begin
        col_d  = 10'd0;
        row_d  = cur_row + 9'd1;
        base_d = cur_base + 19'(H_ACTIVE);
      end else begin
        col_d  = cur_col + 10'd1;
      end
    end
  end

  assign pix_addr_o = cur_base + {9'd0, cur_col};
  assign last_o     = (cur_col == cur_cw - 10'd1) && (cur_row == cur_ch - 9'd1);

  // Position registers update only when loaded or stepped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      base_q <= '0;
      cw_q   <= '0;
      ch_q   <= '0;
    end else if (load_i || advance_i) begin
      col_q  <= col_d;
      row_q  <= row_d;
      base_q <= base_d;
      cw_q   <= cur_cw;
      ch_q   <= cur_ch;
    end
  end

endmodule

// File: rtl/vga_rect_filler.sv
// VRAM rectangle filler: bus initiator that writes a clipped rectangle of a
// constant colour into the 640x480 framebuffer, one pixel per granted cycle.
// Optional macro VGA_FILL_XOR_EN adds a read-modify-write XOR fill mode.
// Bus outputs are registered: the grant seen in a cycle decides the access
// presented in the following cycle.
module vga_rect_filler
  import vga_rect_filler_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [9:0]      x0,
  input  logic [8:0]      y0,
  input  logic [9:0]      width,
  input  logic [8:0]      height,
  input  logic [11:0]     color,
  input  logic            xor_mode,
  output logic            busy,
  output logic            done,
  output logic            bus_req,
  input  logic            bus_gnt,
  output logic            sel,
  output logic [18:0]     addr,
  output logic [2:0]      we,
  output logic [XLEN-1:0] qout,
  input  logic [XLEN-1:0] qin
);

  logic [2:0]      state_q, state_d;
  logic [9:0]      x0_q, x0_d, w_q, w_d;
  logic [8:0]      y0_q, y0_d, h_q, h_d;
  logic [11:0]     color_q, color_d;
  logic            busy_q, busy_d, done_q, done_d, req_q, req_d, sel_q, sel_d;
  logic            all_q, all_d;
  logic [18:0]     addr_q, addr_d;
  logic [2:0]      we_q, we_d;
  logic [XLEN-1:0] qout_q, qout_d, color_ext;
`ifdef VGA_FILL_XOR_EN
  logic            xor_q, xor_d;
`endif

  logic [10:0] room_x;
  logic [9:0]  room_y, clip_w;
  logic [8:0]  clip_h;
  logic        empty;
  logic [18:0] base_w, walk_addr;
  logic        walk_load, walk_adv, walk_last;
  logic        unused_in;

  assign unused_in = ^{xor_mode, qin};
  assign color_ext = {{(XLEN-12){1'b0}}, color_q};

  // Clip the latched command against the framebuffer edges.
  always_comb begin
    room_x = 11'd640 - {1'b0, x0_q};
    room_y = 10'd480 - {1'b0, y0_q};
    clip_w = ({1'b0, w_q} > room_x) ? room_x[9:0] : w_q;
    clip_h = ({1'b0, h_q} > room_y) ? room_y[8:0] : h_q;
    empty  = (x0_q >= 10'd640) || (y0_q >= 9'd480) || (clip_w == 10'd0) || (clip_h == 9'd0);
    base_w = row_base(y0_q, x0_q);
  end

  vga_fill_walker u_walker (
    .clk        (clk),
    .rst        (rst),
    .load_i     (walk_load),
    .advance_i  (walk_adv),
    .cw_i       (clip_w),
    .ch_i       (clip_h),
    .base_i     (base_w),
    .pix_addr_o (walk_addr),
    .last_o     (walk_last)
  );

  // Command FSM and next-cycle bus access selection.
  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    w_d       = w_q;
    h_d       = h_q;
    color_d   = color_q;
`ifdef VGA_FILL_XOR_EN
    xor_d     = xor_q;
`endif
    busy_d    = busy_q;
    done_d    = 1'b0;
    req_d     = req_q;
    sel_d     = 1'b0;
    we_d      = WE_NONE;
    addr_d    = addr_q;
    qout_d    = qout_q;
    all_d     = all_q;
    walk_load = 1'b0;
    walk_adv  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x0_d    = x0;
          y0_d    = y0;
          w_d     = width;
          h_d     = height;
          color_d = color;
`ifdef VGA_FILL_XOR_EN
          xor_d   = xor_mode;
`endif
          busy_d  = 1'b1;
          req_d   = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        all_d = 1'b0;
        if (empty) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          req_d   = 1'b0;
        end else begin
          walk_load = 1'b1;
          state_d   = ST_WRITE;
`ifdef VGA_FILL_XOR_EN
          if (xor_q) begin
            state_d = ST_RD;
            if (bus_gnt) begin
              sel_d  = 1'b1;
              addr_d = walk_addr;
            end
          end else
`endif
          if (bus_gnt) begin
            sel_d    = 1'b1;
            we_d     = WE_PIXEL;
            addr_d   = walk_addr;
            qout_d   = color_ext;
            walk_adv = 1'b1;
            all_d    = walk_last;
          end
        end
      end
      ST_WRITE: begin
        if (all_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          req_d   = 1'b0;
        end else if (bus_gnt) begin
          sel_d    = 1'b1;
          we_d     = WE_PIXEL;
          addr_d   = walk_addr;
          qout_d   = color_ext;
          walk_adv = 1'b1;
          all_d    = walk_last;
        end
      end
`ifdef VGA_FILL_XOR_EN
      ST_RD: begin
        if (sel_q && bus_gnt) begin
          sel_d    = 1'b1;
          we_d     = WE_PIXEL;
          walk_adv = 1'b1;
          all_d    = walk_last;
          state_d  = ST_WR;
        end else if (!sel_q && bus_gnt) begin
          sel_d  = 1'b1;
          addr_d = walk_addr;
        end
      end
      ST_WR: begin
        if (all_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          req_d   = 1'b0;
        end else begin
          state_d = ST_RD;
          if (bus_gnt) begin
            sel_d  = 1'b1;
            addr_d = walk_addr;
          end
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, command latches and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
`ifdef VGA_FILL_XOR_EN
      xor_q   <= 1'b0;
`endif
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      sel_q   <= 1'b0;
      we_q    <= WE_NONE;
      addr_q  <= '0;
      qout_q  <= '0;
      all_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
`ifdef VGA_FILL_XOR_EN
      xor_q   <= xor_d;
`endif
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      qout_q  <= qout_d;
      all_q   <= all_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bus_req = req_q;
  assign sel     = sel_q;
  assign we      = we_q;
  assign addr    = addr_q;
`ifdef VGA_FILL_XOR_EN
  assign qout = (state_q == ST_WR) ? {{(XLEN-12){1'b0}}, qin[11:0] ^ color_q} : qout_q;
`else
  assign qout = qout_q;
`endif

endmodule
